// File: rtl/spio_hss_multiplexer_frame_tx.sv
// HSS frame transmitter: merges NUM_CHANNELS packet streams into 32-bit
// 8b/10b words. Each frame is one header word followed by PKT_BITS/32 data
// words. Channels are picked round-robin and each channel has its own credit
// counter for flow control. Idle K-words are sent when no frame is in flight.
module spio_hss_multiplexer_frame_tx #(
  parameter int NUM_CHANNELS = 8,
  parameter int CH_BITS      = 3,
  parameter int PKT_BITS     = 64,
  parameter int INIT_CREDITS = 4,
  parameter int CREDIT_BITS  = 4
) (
  input  logic                             CLK_IN,
  input  logic                             RESET_IN,
  input  logic                             HANDSHAKE_COMPLETE_IN,
  input  logic [NUM_CHANNELS*PKT_BITS-1:0] TX_PKT_DATA_IN,
  input  logic [NUM_CHANNELS-1:0]          TX_PKT_VLD_IN,
  output logic [NUM_CHANNELS-1:0]          TX_PKT_RDY_OUT,
  input  logic                             CREDIT_RET_VLD_IN,
  input  logic [CH_BITS-1:0]               CREDIT_RET_CH_IN,
  output logic [31:0]                      TXDATA_OUT,
  output logic [3:0]                       TXCHARISK_OUT,
  input  logic                             TXRDY_IN,
  output logic                             CREDIT_ERR_OUT
);

  localparam int WORDS    = PKT_BITS / 32;
  localparam int CNT_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0]            IDLE_WORD = 32'h7C7C7C7C;
  localparam logic [CREDIT_BITS-1:0] INIT_C    = CREDIT_BITS'(INIT_CREDITS);
  localparam logic [CNT_BITS-1:0]    LAST_CNT  = CNT_BITS'(WORDS - 1);

  // ST_IDLE also covers "last data word on the line, waiting to be consumed",
  // so the next header can follow that word with no gap.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t                                    state_q, state_d;
  logic [CNT_BITS-1:0]                       cnt_q, cnt_d;
  logic [PKT_BITS-1:0]                       pkt_q, pkt_d;
  logic [15:0]                               seq_q, seq_d;
  logic [CH_BITS-1:0]                        rr_q, rr_d;
  logic [NUM_CHANNELS-1:0][CREDIT_BITS-1:0]  credit_q, credit_d;
  logic [31:0]                               txdata_q, txdata_d;
  logic [3:0]                                txk_q, txk_d;
  logic                                      err_q, err_d;

  logic [NUM_CHANNELS-1:0] elig_s;
  logic                    grant_found_s;
  logic [CH_BITS-1:0]      grant_s;
  logic                    accept_s;
  logic                    ret_in_range_s;
  int                      idx_s;

  // A channel may be granted when it has a packet, credit, and the link is up.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      elig_s[i] = TX_PKT_VLD_IN[i] & (credit_q[i] != '0) & HANDSHAKE_COMPLETE_IN;
    end
  end

  // Round-robin search: first eligible channel at or after the pointer.
  always_comb begin
    grant_found_s = 1'b0;
    grant_s       = '0;
    idx_s         = 0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx_s = (int'(rr_q) + k) % NUM_CHANNELS;
      if (!grant_found_s && elig_s[idx_s]) begin
        grant_found_s = 1'b1;
        grant_s       = CH_BITS'(idx_s);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Accepting a packet needs a free output slot, so only in ST_IDLE on TXRDY.
  always_comb begin
    accept_s       = TXRDY_IN & (state_q == ST_IDLE) & grant_found_s;
    TX_PKT_RDY_OUT = '0;
    if (accept_s) begin
      TX_PKT_RDY_OUT[grant_s] = 1'b1;
    end else begin
      TX_PKT_RDY_OUT = '0;
    end
  end

  // Framing FSM and output word selection; nothing moves unless TXRDY_IN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pkt_d    = pkt_q;
    seq_d    = seq_q;
    rr_d     = rr_q;
    txdata_d = txdata_q;
    txk_d    = txk_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          pkt_d    = TX_PKT_DATA_IN[int'(grant_s)*PKT_BITS +: PKT_BITS];
          txdata_d = {seq_q, 8'(grant_s), 8'hBC};
          txk_d    = 4'b0001;
          seq_d    = seq_q + 16'd1;
          rr_d     = (int'(grant_s) == NUM_CHANNELS - 1) ? '0 : grant_s + CH_BITS'(1);
          cnt_d    = '0;
          state_d  = ST_DATA;
        end else if (TXRDY_IN) begin
          txdata_d = IDLE_WORD;
          txk_d    = 4'hF;
        end else begin
          txdata_d = txdata_q;
        end
      end
      ST_DATA: begin
        if (TXRDY_IN) begin
          txdata_d = pkt_q[int'(cnt_q)*32 +: 32];
          txk_d    = 4'b0000;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end else begin
          txdata_d = txdata_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        txdata_d = IDLE_WORD;
        txk_d    = 4'hF;
      end
    endcase
  end

  // Credit bookkeeping: grant spends one, a valid return refunds one.
  always_comb begin
    ret_in_range_s = int'(CREDIT_RET_CH_IN) < NUM_CHANNELS;
    credit_d       = credit_q;
    err_d          = err_q;
    if (!HANDSHAKE_COMPLETE_IN) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        credit_d[i] = INIT_C;
      end
    end else begin
      if (CREDIT_RET_VLD_IN && !ret_in_range_s) begin
        err_d = 1'b1;
      end else if (CREDIT_RET_VLD_IN && (credit_q[CREDIT_RET_CH_IN] == INIT_C)) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if ((accept_s && (grant_s == CH_BITS'(i))) &&
            !(CREDIT_RET_VLD_IN && ret_in_range_s && (CREDIT_RET_CH_IN == CH_BITS'(i)) &&
              (credit_q[i] != INIT_C))) begin
          credit_d[i] = credit_q[i] - CREDIT_BITS'(1);
        end else if (!(accept_s && (grant_s == CH_BITS'(i))) &&
                     (CREDIT_RET_VLD_IN && ret_in_range_s && (CREDIT_RET_CH_IN == CH_BITS'(i)) &&
                      (credit_q[i] != INIT_C))) begin
          credit_d[i] = credit_q[i] + CREDIT_BITS'(1);
        end else begin
          credit_d[i] = credit_q[i];
        end
      end
    end
  end

  // State registers with synchronous active-low reset; reset drops any frame.
  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pkt_q    <= '0;
      seq_q    <= 16'h0000;
      rr_q     <= '0;
      credit_q <= {NUM_CHANNELS{INIT_C}};
      txdata_q <= IDLE_WORD;
      txk_q    <= 4'hF;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pkt_q    <= pkt_d;
      seq_q    <= seq_d;
      rr_q     <= rr_d;
      credit_q <= credit_d;
      txdata_q <= txdata_d;
      txk_q    <= txk_d;
      err_q    <= err_d;
    end
  end

  assign TXDATA_OUT     = txdata_q;
  assign TXCHARISK_OUT  = txk_q;
  assign CREDIT_ERR_OUT = err_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_frame_tx.sv
// Directed bench for the HSS frame transmitter (8 channels, 64-bit packets).
module tb_spio_hss_multiplexer_frame_tx;

  logic         clk;
  logic         rst_n;
  logic         hs;
  logic [511:0] pkt_data;
  logic [7:0]   vld;
  logic [7:0]   rdy;
  logic         ret_vld;
  logic [2:0]   ret_ch;
  logic [31:0]  txdata;
  logic [3:0]   txk;
  logic         txrdy;
  logic         err;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [31:0] IDLE_W = 32'h7C7C7C7C;

  spio_hss_multiplexer_frame_tx dut (
    .CLK_IN               (clk),
    .RESET_IN             (rst_n),
    .HANDSHAKE_COMPLETE_IN(hs),
    .TX_PKT_DATA_IN       (pkt_data),
    .TX_PKT_VLD_IN        (vld),
    .TX_PKT_RDY_OUT       (rdy),
    .CREDIT_RET_VLD_IN    (ret_vld),
    .CREDIT_RET_CH_IN     (ret_ch),
    .TXDATA_OUT           (txdata),
    .TXCHARISK_OUT        (txk),
    .TXRDY_IN             (txrdy),
    .CREDIT_ERR_OUT       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hs = 1'b1; vld = 8'h00; ret_vld = 1'b0; ret_ch = 3'd0;
    txrdy = 1'b1; pkt_data = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // Counts header words seen over n cycles; remembers the first header.
  task automatic count_headers(input int n, output int cnt, output logic [31:0] first);
    cnt = 0; first = 32'h0;
    for (int c = 0; c < n; c++) begin
      step();
      if (txk == 4'b0001) begin
        if (cnt == 0) first = txdata;
        cnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hs = 1'b1; vld = 8'h00; ret_vld = 1'b0; ret_ch = 3'd0;
    txrdy = 1'b1; pkt_data = '0;
    step(); step();
    n_cmp++; if (txdata !== IDLE_W) begin n_fail++; $display("FAIL reset_txdata: got %h expected %h", txdata, IDLE_W); end
    n_cmp++; if (txk !== 4'hF) begin n_fail++; $display("FAIL reset_charisk: got %h expected f", txk); end
    n_cmp++; if (rdy !== 8'h00) begin n_fail++; $display("FAIL reset_rdy: got %h expected 00", rdy); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    pkt_data[3*64 +: 64] = 64'h1122334455667788;
    vld = 8'h08;
    #1;
    n_cmp++; if (rdy !== 8'h08) begin n_fail++; $display("FAIL single_rdy: got %h expected 08", rdy); end
    step();
    vld = 8'h00;
    n_cmp++; if (txdata !== 32'h000003BC || txk !== 4'b0001) begin n_fail++; $display("FAIL single_hdr: got %h/%h expected 000003bc/1", txdata, txk); end
    step();
    n_cmp++; if (txdata !== 32'h55667788 || txk !== 4'h0) begin n_fail++; $display("FAIL single_w0: got %h/%h expected 55667788/0", txdata, txk); end
    step();
    n_cmp++; if (txdata !== 32'h11223344 || txk !== 4'h0) begin n_fail++; $display("FAIL single_w1: got %h/%h expected 11223344/0", txdata, txk); end
    step();
    n_cmp++; if (txdata !== IDLE_W || txk !== 4'hF) begin n_fail++; $display("FAIL single_idle: got %h/%h expected 7c7c7c7c/f", txdata, txk); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_hdr;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      pkt_data[c*64 +: 64] = {32'h2000_0000 + 32'(c), 32'h1000_0000 + 32'(c)};
    end
    vld = 8'hFF;
    step();
    for (int f = 0; f < 9; f++) begin
      exp_hdr = {16'(f), 8'(f % 8), 8'hBC};
      n_cmp++; if (txdata !== exp_hdr || txk !== 4'b0001) begin n_fail++; $display("FAIL b2b_hdr%0d: got %h/%h expected %h/1", f, txdata, txk, exp_hdr); end
      step();
      n_cmp++; if (txdata !== 32'h1000_0000 + 32'(f % 8)) begin n_fail++; $display("FAIL b2b_lo%0d: got %h expected %h", f, txdata, 32'h1000_0000 + 32'(f % 8)); end
      if (f == 8) vld = 8'h00;
      step();
      n_cmp++; if (txdata !== 32'h2000_0000 + 32'(f % 8)) begin n_fail++; $display("FAIL b2b_hi%0d: got %h expected %h", f, txdata, 32'h2000_0000 + 32'(f % 8)); end
      step();
    end
    n_cmp++; if (txdata !== IDLE_W) begin n_fail++; $display("FAIL b2b_idle: got %h expected 7c7c7c7c", txdata); end
  endtask

  task automatic test_credits();
    int cnt; logic [31:0] first;
    do_reset();
    pkt_data[2*64 +: 64] = 64'hCAFE0002_BEEF0002;
    vld = 8'h04;
    count_headers(20, cnt, first);
    n_cmp++; if (cnt !== 4) begin n_fail++; $display("FAIL credit_frames: got %0d expected 4", cnt); end
    n_cmp++; if (first !== 32'h000002BC) begin n_fail++; $display("FAIL credit_first: got %h expected 000002bc", first); end
    n_cmp++; if (rdy !== 8'h00 || txdata !== IDLE_W) begin n_fail++; $display("FAIL credit_stall: got %h/%h expected 00/7c7c7c7c", rdy, txdata); end
    ret_vld = 1'b1; ret_ch = 3'd2;
    step();
    ret_vld = 1'b0;
    #1;
    n_cmp++; if (rdy !== 8'h04) begin n_fail++; $display("FAIL credit_ret_rdy: got %h expected 04", rdy); end
    count_headers(5, cnt, first);
    n_cmp++; if (cnt !== 1 || first !== 32'h000402BC) begin n_fail++; $display("FAIL credit_fifth: got %0d/%h expected 1/000402bc", cnt, first); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL credit_noerr: got %b expected 0", err); end
    vld = 8'h00;
  endtask

  task automatic test_credit_err();
    int cnt; logic [31:0] first;
    do_reset();
    ret_vld = 1'b1; ret_ch = 3'd5;
    step();
    ret_vld = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err); end
    for (int c = 0; c < 5; c++) step();
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err); end
    pkt_data[5*64 +: 64] = 64'h55555555_AAAAAAAA;
    vld = 8'h20;
    count_headers(25, cnt, first);
    n_cmp++; if (cnt !== 4) begin n_fail++; $display("FAIL err_credit_kept: got %0d expected 4", cnt); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_still: got %b expected 1", err); end
    vld = 8'h00;
  endtask

  task automatic test_handshake();
    int cnt; logic [31:0] first;
    do_reset();
    pkt_data[1*64 +: 64] = 64'hDDDD0001_EEEE0001;
    vld = 8'h02;
    step();
    hs = 1'b0; txrdy = 1'b0;
    n_cmp++; if (txdata !== 32'h000001BC) begin n_fail++; $display("FAIL hs_hdr: got %h expected 000001bc", txdata); end
    step();
    n_cmp++; if (txdata !== 32'h000001BC) begin n_fail++; $display("FAIL hs_hold_hdr: got %h expected 000001bc", txdata); end
    txrdy = 1'b1; step();
    n_cmp++; if (txdata !== 32'hEEEE0001) begin n_fail++; $display("FAIL hs_w0: got %h expected eeee0001", txdata); end
    txrdy = 1'b0; step();
    n_cmp++; if (txdata !== 32'hEEEE0001) begin n_fail++; $display("FAIL hs_hold_w0: got %h expected eeee0001", txdata); end
    txrdy = 1'b1; step();
    n_cmp++; if (txdata !== 32'hDDDD0001) begin n_fail++; $display("FAIL hs_w1: got %h expected dddd0001", txdata); end
    n_cmp++; if (rdy !== 8'h00) begin n_fail++; $display("FAIL hs_no_accept: got %h expected 00", rdy); end
    step();
    n_cmp++; if (txdata !== IDLE_W || txk !== 4'hF) begin n_fail++; $display("FAIL hs_idle: got %h/%h expected 7c7c7c7c/f", txdata, txk); end
    hs = 1'b1;
    count_headers(40, cnt, first);
    n_cmp++; if (cnt !== 4) begin n_fail++; $display("FAIL hs_reload: got %0d expected 4", cnt); end
    n_cmp++; if (first !== 32'h000101BC) begin n_fail++; $display("FAIL hs_seq: got %h expected 000101bc", first); end
    vld = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_credits();
    test_credit_err();
    test_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
